car_sequencer: RTL
==================

CAR_SEQUENCER -- requirements
Module: car_sequencer

Interface
REQ-001 Parameter CAR_BITS, default 6, width of every control-address bus.
REQ-002 Parameter STALL_MAX, default 15, consecutive stall cycles tolerated before bus error.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 CARnext  input  CAR_BITS  next control address chosen by the CAR latch-control stage.
REQ-006 stall  input  1  memory not ready; hold current micro-step.
REQ-007 IRQ  input  1  raw interrupt request, level or single-cycle pulse.
REQ-008 GIE  input  1  global interrupt enable from status register.
REQ-009 CAR  output  CAR_BITS  registered current control address; indexes control ROM.
REQ-010 CARold  output  CAR_BITS  sequential successor address, fed back to latch control.
REQ-011 IF  output  1  instruction-fetch boundary flag, fed to latch control.
REQ-012 INTREQ  output  1  qualified pending interrupt, fed to latch control.
REQ-013 INTACK  output  1  one-cycle interrupt-accepted pulse.
REQ-014 busErr  output  1  sticky stall-timeout error.
REQ-015 illegal  output  1  sticky flag: CAR loaded above CAR_MAX.

Function
REQ-016 Non-stall cycle: CAR <= CARnext; stall=1: CAR holds.
REQ-017 CARold SHALL equal CAR+1 modulo 2^CAR_BITS, combinational; CAR=2^CAR_BITS-1 gives CARold=0.
REQ-018 IF SHALL be 1 exactly when CAR==CAR_FETCH and stall=0.
REQ-019 intPend register SHALL set on any cycle with IRQ=1 and clear on the cycle INTACK is 1; set and clear in the same cycle SHALL leave it set.
REQ-020 INTREQ SHALL equal intPend AND GIE, combinational.
REQ-021 INTACK SHALL be 1 for exactly the cycle after CAR is loaded with CAR_INT4 (registered); held CAR_INT4 during stall SHALL NOT re-pulse.
REQ-022 Entry sequence SHALL be tracked by state machine IDLE -> ENTRY on CAR load of CAR_INT0 -> DONE on load of CAR_INT4 -> IDLE next cycle; load of any address outside CAR_INT0..CAR_INT4 while in ENTRY SHALL return to IDLE without INTACK.
REQ-023 stallCnt SHALL increment each stall cycle, saturate at STALL_MAX, clear on any non-stall cycle.
REQ-024 busErr SHALL set in the cycle after stallCnt reaches STALL_MAX with stall still 1; clears only on rst.
REQ-025 illegal SHALL set in the cycle after a CAR load exceeding CAR_MAX; clears only on rst; CAR still loads the value.
REQ-026 busErr and illegal SHALL NOT affect CAR sequencing.

Reset
REQ-027 rst=1 at a clock edge: CAR=CAR_RESET, intPend=0, state=IDLE, stallCnt=0, INTACK=0, busErr=0, illegal=0; overrides stall and IRQ.
REQ-028 rst mid-entry-sequence SHALL abandon it with no INTACK pulse.
REQ-029 Before the first clock, outputs are undefined; the bench checks only after the first reset edge.

Structure
REQ-030 CAR_BITS default, CAR_RESET, CAR_FETCH, CAR_INT0..CAR_INT4, CAR_MAX SHALL come from the shared MACROS constants package, identical to the latch-control stage.
REQ-031 Entry state encoding SHALL be a localparam set private to this module.
REQ-032 One sub-module: car_stall_timer (stallCnt plus busErr); all else inline.

Verification
REQ-033 rst=1 one cycle, CARnext=9 -> CAR=CAR_RESET, CARold=CAR_RESET+1, all flags 0.
REQ-034 CARnext=63, stall=0, one edge -> CAR=63, CARold=0; then stall=1 three cycles with CARnext=5 -> CAR stays 63.
REQ-035 IRQ pulse one cycle, GIE=0 -> INTREQ=0; GIE=1 -> INTREQ=1; drive CAR_INT0..CAR_INT4 over 5 edges -> INTACK=1 for one cycle after the CAR_INT4 edge, intPend=0 after.
REQ-036 Load CAR_INT0, CAR_INT1, then rst -> state IDLE, INTACK never 1, intPend=0.
REQ-037 stall=1 for STALL_MAX+1 cycles -> busErr=1 from cycle STALL_MAX+1, still 1 after stall drops; stall 14 cycles then 0 -> busErr=0.
REQ-038 CARnext=CAR_MAX+1 -> CAR loads it, illegal=1 next cycle, persists until rst.

Source files
------------

// File: rtl/car_sequencer_pkg.sv
// Shared micro-sequencer constants. The CAR latch-control stage imports the same
// package, so both stages always agree on the control-ROM address map.
package car_sequencer_pkg;

  localparam int unsigned CAR_BITS_DEFAULT = 6;

  // Control-ROM address map
  localparam int unsigned CAR_RESET = 0;
  localparam int unsigned CAR_FETCH = 1;
  localparam int unsigned CAR_INT0  = 40;
  localparam int unsigned CAR_INT1  = 41;
  localparam int unsigned CAR_INT2  = 42;
  localparam int unsigned CAR_INT3  = 43;
  localparam int unsigned CAR_INT4  = 44;
  localparam int unsigned CAR_MAX   = 47;

  // True when addr lies inside the interrupt-entry microroutine.
  function automatic logic car_in_int_range(input int unsigned addr);
    return (addr >= CAR_INT0) && (addr <= CAR_INT4);
  endfunction

endpackage

// File: rtl/car_sequencer_if.sv
// Bus between the CAR latch-control stage (master) and the CAR sequencer (slave).
interface car_sequencer_if
  import car_sequencer_pkg::*;
#(
  parameter int unsigned CAR_BITS = CAR_BITS_DEFAULT
);

  logic [CAR_BITS-1:0] CARnext;
  logic                stall;
  logic                IRQ;
  logic                GIE;
  logic [CAR_BITS-1:0] CAR;
  logic [CAR_BITS-1:0] CARold;
  logic                IF;
  logic                INTREQ;
  logic                INTACK;
  logic                busErr;
  logic                illegal;

  modport master (
    output CARnext, stall, IRQ, GIE,
    input  CAR, CARold, IF, INTREQ, INTACK, busErr, illegal
  );

  modport slave (
    input  CARnext, stall, IRQ, GIE,
    output CAR, CARold, IF, INTREQ, INTACK, busErr, illegal
  );

endinterface

// File: rtl/car_stall_timer.sv
// Counts consecutive stall cycles and raises a sticky bus error once the memory has
// been stalled for longer than STALL_MAX cycles.
module car_stall_timer #(
  parameter int unsigned STALL_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic stall_i,
  output logic bus_err_o
);

  localparam int unsigned CntW = (STALL_MAX < 1) ? 1 : $clog2(STALL_MAX + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STALL_MAX);

  logic [CntW-1:0] stall_cnt_q, stall_cnt_d;
  logic            bus_err_q, bus_err_d;

  // Saturating stall counter; error latches when a stall outlives the saturated count
  always_comb begin
    stall_cnt_d = '0;
    bus_err_d   = bus_err_q;
    if (stall_i) begin
      stall_cnt_d = (stall_cnt_q == CntMax) ? stall_cnt_q : stall_cnt_q + 1'b1;
      if (stall_cnt_q == CntMax) begin
        bus_err_d = 1'b1;
      end
    end
  end

  // Counter and sticky error registers
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign bus_err_o = bus_err_q;

endmodule

// File: rtl/car_sequencer.sv
// Control-address register (CAR) sequencer: holds the current microprogram address,
// supplies the sequential successor, qualifies interrupts and tracks the
// interrupt-entry microroutine so the acknowledge pulse fires exactly once.
module car_sequencer
  import car_sequencer_pkg::*;
#(
  parameter int unsigned CAR_BITS  = CAR_BITS_DEFAULT,
  parameter int unsigned STALL_MAX = 15
) (
  input  logic            clk,
  input  logic            rst,
  car_sequencer_if.slave  bus
);

  // Entry-sequence states are private to this block
  typedef enum logic [1:0] {StIdle, StEntry, StDone} entry_state_e;

  localparam logic [CAR_BITS-1:0] CarReset = CAR_BITS'(CAR_RESET);
  localparam logic [CAR_BITS-1:0] CarFetch = CAR_BITS'(CAR_FETCH);
  localparam logic [CAR_BITS-1:0] CarInt0  = CAR_BITS'(CAR_INT0);
  localparam logic [CAR_BITS-1:0] CarInt4  = CAR_BITS'(CAR_INT4);
  localparam logic [CAR_BITS-1:0] CarMax   = CAR_BITS'(CAR_MAX);

  logic [CAR_BITS-1:0] car_q, car_d;
  entry_state_e        state_q, state_d;
  logic                int_pend_q, int_pend_d;
  logic                illegal_q, illegal_d;
  logic                load;
  logic                intack;
  logic                next_in_int;

  assign load        = ~bus.stall;
  assign intack      = (state_q == StDone);
  assign next_in_int = car_in_int_range(32'(bus.CARnext));

  // Next-state for CAR, pending interrupt, illegal flag and entry tracker
  always_comb begin
    car_d      = load ? bus.CARnext : car_q;
    int_pend_d = bus.IRQ | (int_pend_q & ~intack);
    illegal_d  = illegal_q | (load & (bus.CARnext > CarMax));
    state_d    = state_q;
    unique case (state_q)
      StIdle: begin
        if (load && (bus.CARnext == CarInt0)) begin
          state_d = StEntry;
        end
      end
      StEntry: begin
        if (load) begin
          if (bus.CARnext == CarInt4) begin
            state_d = StDone;
          end else if (!next_in_int) begin
            state_d = StIdle;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset dominates stall and IRQ
  always_ff @(posedge clk) begin
    if (rst) begin
      car_q      <= CarReset;
      state_q    <= StIdle;
      int_pend_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      car_q      <= car_d;
      state_q    <= state_d;
      int_pend_q <= int_pend_d;
      illegal_q  <= illegal_d;
    end
  end

  car_stall_timer #(
    .STALL_MAX (STALL_MAX)
  ) u_stall_timer (
    .clk       (clk),
    .rst       (rst),
    .stall_i   (bus.stall),
    .bus_err_o (bus.busErr)
  );

  assign bus.CAR     = car_q;
  assign bus.CARold  = car_q + 1'b1;
  assign bus.IF      = (car_q == CarFetch) & ~bus.stall;
  assign bus.INTREQ  = int_pend_q & bus.GIE;
  assign bus.INTACK  = intack;
  assign bus.illegal = illegal_q;

endmodule
